// File: rtl/spu_regfile_wb.sv
`default_nettype none
// ============================================================================
// Module   : spu_regfile_wb
// Purpose  : 128 x 128-bit register file that sinks the even and odd
//            writeback packets and supplies six registered read operands
//            (ra/rb/rc for each pipe), with built-in write-to-read bypass.
// Ports    : clk, reset (async, active-high)
//            wb_even_pkt/wb_even_vld, wb_odd_pkt/wb_odd_vld : writeback in
//              packet layout (big-endian): [0:ADDR_W-1] = rt address,
//              [ADDR_W:PKT_W-1] = data
//            stall                       : hold all six read outputs
//            r{a,b,c}_{e,o}_addr         : read source addresses
//            r{a,b,c}_{e,o}_data         : registered read operands
//            wr_conflict                 : both pipes hit one address last edge
// Revision : 1.0 - initial release
// ============================================================================
module spu_regfile_wb #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7,
  parameter int NREG   = 128,
  parameter int PKT_W  = 135
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [0:PKT_W-1]    wb_even_pkt,
  input  logic                wb_even_vld,
  input  logic [0:PKT_W-1]    wb_odd_pkt,
  input  logic                wb_odd_vld,
  input  logic                stall,
  input  logic [0:ADDR_W-1]   ra_e_addr,
  input  logic [0:ADDR_W-1]   rb_e_addr,
  input  logic [0:ADDR_W-1]   rc_e_addr,
  input  logic [0:ADDR_W-1]   ra_o_addr,
  input  logic [0:ADDR_W-1]   rb_o_addr,
  input  logic [0:ADDR_W-1]   rc_o_addr,
  output logic [0:DATA_W-1]   ra_e_data,
  output logic [0:DATA_W-1]   rb_e_data,
  output logic [0:DATA_W-1]   rc_e_data,
  output logic [0:DATA_W-1]   ra_o_data,
  output logic [0:DATA_W-1]   rb_o_data,
  output logic [0:DATA_W-1]   rc_o_data,
  output logic                wr_conflict
);

  localparam int NPORT = 6;

  // Packet field decode
  logic [0:ADDR_W-1] even_addr;
  logic [0:ADDR_W-1] odd_addr;
  logic [0:DATA_W-1] even_data;
  logic [0:DATA_W-1] odd_data;

  assign even_addr = wb_even_pkt[0:ADDR_W-1];
  assign even_data = wb_even_pkt[ADDR_W:PKT_W-1];
  assign odd_addr  = wb_odd_pkt[0:ADDR_W-1];
  assign odd_data  = wb_odd_pkt[ADDR_W:PKT_W-1];

  // Both pipes targeting one register: even owns the write, odd is dropped.
  logic same_addr;
  logic odd_we;

  assign same_addr = wb_even_vld && wb_odd_vld && (even_addr == odd_addr);
  assign odd_we    = wb_odd_vld && !same_addr;

  // --------------------------------------------------------------------------
  // Storage array (writes never depend on stall)
  // --------------------------------------------------------------------------
  logic [0:DATA_W-1] mem [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (odd_we) begin
        mem[odd_addr] <= odd_data;
      end
      if (wb_even_vld) begin
        mem[even_addr] <= even_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports with bypass
  // --------------------------------------------------------------------------
  logic [0:ADDR_W-1] rd_addr [NPORT];
  logic [0:DATA_W-1] rd_next [NPORT];
  logic [0:DATA_W-1] rd_q    [NPORT];

  assign rd_addr[0] = ra_e_addr;
  assign rd_addr[1] = rb_e_addr;
  assign rd_addr[2] = rc_e_addr;
  assign rd_addr[3] = ra_o_addr;
  assign rd_addr[4] = rb_o_addr;
  assign rd_addr[5] = rc_o_addr;

  // Later assignments take precedence, so even is applied last to win
  // over odd, and both win over the pre-edge array contents.
  always_comb begin
    for (int k = 0; k < NPORT; k++) begin
      rd_next[k] = mem[rd_addr[k]];
      if (wb_odd_vld && (odd_addr == rd_addr[k])) begin
        rd_next[k] = odd_data;
      end
      if (wb_even_vld && (even_addr == rd_addr[k])) begin
        rd_next[k] = even_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NPORT; k++) begin
        rd_q[k] <= '0;
      end
      wr_conflict <= 1'b0;
    end else begin
      if (!stall) begin
        for (int k = 0; k < NPORT; k++) begin
          rd_q[k] <= rd_next[k];
        end
      end
      wr_conflict <= same_addr;
    end
  end

  assign ra_e_data = rd_q[0];
  assign rb_e_data = rd_q[1];
  assign rc_e_data = rd_q[2];
  assign ra_o_data = rd_q[3];
  assign rb_o_data = rd_q[4];
  assign rc_o_data = rd_q[5];

endmodule
`default_nettype wire

// File: tb/tb_spu_regfile_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_spu_regfile_wb
// Purpose  : Self-checking bench for spu_regfile_wb: directed vector table,
//            hand-written stall / reset sequences, and randomized traffic
//            checked against a post-write-state register file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spu_regfile_wb;

  logic          clk = 1'b0;
  logic          reset;
  logic [0:134]  wb_even_pkt;
  logic          wb_even_vld;
  logic [0:134]  wb_odd_pkt;
  logic          wb_odd_vld;
  logic          stall;
  logic [0:6]    ra_e_addr, rb_e_addr, rc_e_addr;
  logic [0:6]    ra_o_addr, rb_o_addr, rc_o_addr;
  logic [0:127]  ra_e_data, rb_e_data, rc_e_data;
  logic [0:127]  ra_o_data, rb_o_data, rc_o_data;
  logic          wr_conflict;

  int total  = 0;
  int passed = 0;

  spu_regfile_wb dut (
    .clk         (clk),
    .reset       (reset),
    .wb_even_pkt (wb_even_pkt),
    .wb_even_vld (wb_even_vld),
    .wb_odd_pkt  (wb_odd_pkt),
    .wb_odd_vld  (wb_odd_vld),
    .stall       (stall),
    .ra_e_addr   (ra_e_addr),
    .rb_e_addr   (rb_e_addr),
    .rc_e_addr   (rc_e_addr),
    .ra_o_addr   (ra_o_addr),
    .rb_o_addr   (rb_o_addr),
    .rc_o_addr   (rc_o_addr),
    .ra_e_data   (ra_e_data),
    .rb_e_data   (rb_e_data),
    .rc_e_data   (rc_e_data),
    .ra_o_data   (ra_o_data),
    .rb_o_data   (rb_o_data),
    .rc_o_data   (rc_o_data),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [0:127] act, input logic [0:127] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: plain array holding the architectural register state.
  logic [0:127] mm [128];
  logic [0:127] exp_out [6];
  logic         exp_c;

  task automatic model_clear();
    for (int i = 0; i < 128; i++) mm[i] = '0;
    for (int k = 0; k < 6; k++) exp_out[k] = '0;
    exp_c = 1'b0;
  endtask

  // Applies the current inputs to the model (post-write state, even written
  // last so it wins a shared address), clocks the DUT, compares everything.
  task automatic model_edge();
    logic [0:6] a [6];
    logic [0:127] act [6];
    a[0] = ra_e_addr; a[1] = rb_e_addr; a[2] = rc_e_addr;
    a[3] = ra_o_addr; a[4] = rb_o_addr; a[5] = rc_o_addr;
    if (wb_odd_vld)  mm[wb_odd_pkt[0:6]]  = wb_odd_pkt[7:134];
    if (wb_even_vld) mm[wb_even_pkt[0:6]] = wb_even_pkt[7:134];
    exp_c = wb_even_vld && wb_odd_vld && (wb_even_pkt[0:6] == wb_odd_pkt[0:6]);
    if (!stall) for (int k = 0; k < 6; k++) exp_out[k] = mm[a[k]];
    @(posedge clk); #1;
    act[0] = ra_e_data; act[1] = rb_e_data; act[2] = rc_e_data;
    act[3] = ra_o_data; act[4] = rb_o_data; act[5] = rc_o_data;
    for (int k = 0; k < 6; k++) chk($sformatf("rand_port%0d", k), act[k], exp_out[k]);
    chk("rand_conflict", {127'd0, wr_conflict}, {127'd0, exp_c});
  endtask

  task automatic idle_inputs();
    wb_even_pkt = '0; wb_even_vld = 1'b0;
    wb_odd_pkt  = '0; wb_odd_vld  = 1'b0;
    stall = 1'b0;
    ra_e_addr = '0; rb_e_addr = '0; rc_e_addr = '0;
    ra_o_addr = '0; rb_o_addr = '0; rc_o_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [0:6] rnd_addr();
    logic [6:0] v;
    v = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 3)) : 7'($urandom_range(0, 127));
    return v;
  endfunction

  typedef struct {
    logic         ev;
    logic [0:6]   ea;
    logic [0:127] ed;
    logic         ov;
    logic [0:6]   oa;
    logic [0:127] od;
    logic         st;
    logic [0:6]   rd;
    logic [0:127] exp_d;
    logic         exp_c;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [0:127] a5;
    a5 = {16{8'hA5}};
    tbl[0]  = '{1'b1, 7'd10, a5,          1'b0, 7'd0,   128'h0,    1'b0, 7'd10,  a5,          1'b0};
    tbl[1]  = '{1'b0, 7'd0,  128'h0,      1'b0, 7'd0,   128'h0,    1'b0, 7'd10,  a5,          1'b0};
    tbl[2]  = '{1'b0, 7'd0,  128'h0,      1'b1, 7'd3,   128'h1234, 1'b0, 7'd3,   128'h1234,   1'b0};
    tbl[3]  = '{1'b1, 7'd20, 128'h1,      1'b1, 7'd20,  128'h2,    1'b0, 7'd20,  128'h1,      1'b1};
    tbl[4]  = '{1'b0, 7'd0,  128'h0,      1'b0, 7'd0,   128'h0,    1'b0, 7'd20,  128'h1,      1'b0};
    tbl[5]  = '{1'b0, 7'd0,  128'h0,      1'b0, 7'd0,   128'hDEAD, 1'b0, 7'd0,   128'h0,      1'b0};
    tbl[6]  = '{1'b0, 7'd0,  128'h0,      1'b0, 7'd0,   128'h0,    1'b0, 7'd3,   128'h1234,   1'b0};
    tbl[7]  = '{1'b1, 7'd0,  128'hCAFE,   1'b0, 7'd0,   128'h0,    1'b1, 7'd0,   128'h1234,   1'b0};
    tbl[8]  = '{1'b0, 7'd0,  128'h0,      1'b0, 7'd0,   128'h0,    1'b0, 7'd0,   128'hCAFE,   1'b0};
    tbl[9]  = '{1'b1, 7'd127,128'hC0DE,   1'b1, 7'd126, 128'hF00D, 1'b0, 7'd126, 128'hF00D,   1'b0};
    tbl[10] = '{1'b0, 7'd0,  128'h0,      1'b0, 7'd0,   128'h0,    1'b0, 7'd127, 128'hC0DE,   1'b0};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ra_e", ra_e_data, 128'h0);
    chk("reset_rc_o", rc_o_data, 128'h0);
    chk("reset_conflict", {127'd0, wr_conflict}, 128'h0);
    reset = 1'b0;

    // Reset then read
    ra_e_addr = 7'd5; rc_o_addr = 7'd127;
    tick();
    chk("post_reset_ra_e", ra_e_data, 128'h0);
    chk("post_reset_rc_o", rc_o_data, 128'h0);
    chk("post_reset_conflict", {127'd0, wr_conflict}, 128'h0);

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      idle_inputs();
      wb_even_vld = tbl[i].ev; wb_even_pkt = {tbl[i].ea, tbl[i].ed};
      wb_odd_vld  = tbl[i].ov; wb_odd_pkt  = {tbl[i].oa, tbl[i].od};
      stall = tbl[i].st;
      ra_e_addr = tbl[i].rd; rb_o_addr = tbl[i].rd;
      tick();
      chk($sformatf("vec%0d_ra_e", i), ra_e_data, tbl[i].exp_d);
      chk($sformatf("vec%0d_rb_o", i), rb_o_data, tbl[i].exp_d);
      chk($sformatf("vec%0d_conflict", i), {127'd0, wr_conflict}, {127'd0, tbl[i].exp_c});
    end

    // Stall hold: ra_o holds FF while r0 is rewritten
    idle_inputs();
    wb_even_vld = 1'b1; wb_even_pkt = {7'd50, 128'hFF}; ra_o_addr = 7'd50;
    tick();
    chk("stall_setup", ra_o_data, 128'hFF);
    stall = 1'b1; wb_even_pkt = {7'd0, 128'hBEEF}; ra_o_addr = 7'd0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("stall_hold%0d", c), ra_o_data, 128'hFF);
    end
    stall = 1'b0; wb_even_vld = 1'b0;
    tick();
    chk("stall_release", ra_o_data, 128'hBEEF);

    // Mid-run asynchronous reset
    wb_even_vld = 1'b1; wb_even_pkt = {7'd9, 128'h55}; ra_e_addr = 7'd9;
    tick();
    chk("r9_write", ra_e_data, 128'h55);
    wb_even_vld = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_reset_ra_e", ra_e_data, 128'h0);
    chk("async_reset_ra_o", ra_o_data, 128'h0);
    #1;
    reset = 1'b0;
    model_clear();
    idle_inputs();
    ra_e_addr = 7'd9;
    model_edge();
    chk("r9_after_reset", ra_e_data, 128'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      wb_even_vld = ($urandom_range(0, 2) != 0);
      wb_odd_vld  = ($urandom_range(0, 2) != 0);
      wb_even_pkt = {rnd_addr(), rnd128()};
      wb_odd_pkt  = {rnd_addr(), rnd128()};
      stall = ($urandom_range(0, 4) == 0);
      ra_e_addr = rnd_addr(); rb_e_addr = rnd_addr(); rc_e_addr = rnd_addr();
      ra_o_addr = rnd_addr(); rb_o_addr = rnd_addr(); rc_o_addr = rnd_addr();
      model_edge();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spu_regfile_wb.md
Name: spu_regfile_wb

Overview:
- 128-entry x 128-bit register file; the writeback sink for the even and odd execution pipes.
- Consumes the final-stage 135-bit writeback packets ({rt_addr[0:6], data[0:127]}) from the even and odd forwarding stages.
- Supplies six registered operands (ra/rb/rc for each pipe) to the register-fetch stage.
- Write-to-read bypass is built in, so a same-cycle writeback is never lost to a read.

Parameters:
- DATA_W, 128, operand/data width.
- ADDR_W, 7, register address width.
- NREG, 128, number of registers (2**ADDR_W).
- PKT_W, 135, writeback packet width (ADDR_W+DATA_W).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- wb_even_pkt  in  PKT_W  even-pipe writeback packet; [0:6]=rt addr, [7:134]=data.
- wb_even_vld  in  1  even packet valid.
- wb_odd_pkt  in  PKT_W  odd-pipe writeback packet, same format.
- wb_odd_vld  in  1  odd packet valid.
- stall  in  1  hold all read output registers.
- ra_e_addr, rb_e_addr, rc_e_addr  in  ADDR_W each  even-pipe source addresses.
- ra_o_addr, rb_o_addr, rc_o_addr  in  ADDR_W each  odd-pipe source addresses.
- ra_e_data, rb_e_data, rc_e_data  out  DATA_W each  even-pipe operands, registered.
- ra_o_data, rb_o_data, rc_o_data  out  DATA_W each  odd-pipe operands, registered.
- wr_conflict  out  1  registered flag: both pipes wrote the same address in the previous cycle.

Behaviour:
- Reset (async, active-high): all NREG entries, all six read outputs and wr_conflict go to 0 immediately. They stay 0 while reset is high.
- Bit numbering is big-endian ([0] = MSB). Packet fields are decoded as addr = pkt[0:6], data = pkt[7:134].
- A packet with vld=0 is ignored entirely, including an all-zero packet. Address 0 is a legal register.

Write port:
- On each rising edge, if wb_even_vld=1, then mem[even addr] <= even data.
- On each rising edge, if wb_odd_vld=1, then mem[odd addr] <= odd data.
- If both are valid with equal addresses, the even data is written and the odd data is dropped; wr_conflict <= 1 on that edge, otherwise wr_conflict <= 0.
- Writes are independent of stall.

Read port (x6, identical):
- Latency is 1 cycle: the address presented before edge N appears on the output after edge N.
- On each rising edge with stall=0, out <= the first match in this priority order:
  1. even data, if wb_even_vld and even addr == read addr;
  2. odd data, if wb_odd_vld and odd addr == read addr;
  3. otherwise, mem[read addr] as it was before the edge.
- The outcome equals reading the post-write state, with even winning a conflict.
- With stall=1, all six outputs hold their value. Writes during the stall still commit.
- Reads after the stall releases return the updated contents.
- Any subset of the six ports may share an address; each port resolves independently.

Other rules:
- No X propagation: read addresses are always in range, since NREG = 2**ADDR_W.
- Reset asserted mid-operation clears the array and outputs asynchronously. An in-flight write on that edge is discarded.
- The first post-reset edge behaves normally.

Test Plan:
- Reset then read: assert reset, release; ra_e_addr=5, rc_o_addr=127 -> after 1 edge, ra_e_data=0, rc_o_data=0, wr_conflict=0.
- Write-then-read: even pkt {7'd10, 128'hA5A5...A5} vld for 1 cycle; next cycle rb_o_addr=10 -> rb_o_data=128'hA5A5...A5 one edge later.
- Same-cycle bypass: odd pkt {7'd3, 128'h1234} vld while ra_e_addr=3 and rb_e_addr=3 -> both outputs =128'h1234 after that same edge. Reading r3 next cycle (no write) -> still 128'h1234.
- Dual-write conflict: even {7'd20, 128'h1}, odd {7'd20, 128'h2}, both vld; rc_e_addr=20 -> rc_e_data=128'h1 and wr_conflict=1 after the edge; the following read of r20 returns 128'h1; wr_conflict returns to 0 next edge.
- Stall hold: ra_o_data=128'hFF, stall=1, even write {7'd0, 128'hBEEF} with ra_o_addr=0 for 3 cycles -> ra_o_data stays 128'hFF. Release stall -> 128'hBEEF one edge later.
- Invalid packet and mid-run reset: wb_odd_pkt={7'd0, 128'hDEAD} with vld=0 -> r0 unchanged (0). Write r9=128'h55, then pulse reset between edges -> all outputs drop to 0 immediately; a read of r9 afterwards returns 0.
